// File: rtl/rv32i_cpu.sv
// rv32i_cpu: 5-stage in-order RV32I subset pipeline with a 256-word data RAM and an LED register at 0x1000.
// Define FORWARD_EN to add EX operand forwarding from EX/MEM and MEM/WB; otherwise only the register-file bypass exists.
module rv32i_cpu (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    output logic [5:0]  led
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_PASSB
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
`ifdef FORWARD_EN
        logic [4:0]  rs1;
        logic [4:0]  rs2;
`endif
        logic [4:0]  rd;
        alu_op_t     alu_op;
        logic        use_imm;
        logic        reg_we;
        logic        mem_we;
        logic        mem_re;
        logic        is_beq;
        logic        is_bne;
        logic        is_jal;
    } idex_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_we;
        logic        mem_re;
    } exmem_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_we;
    } memwb_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;
    logic [5:0]  led_q, led_d;
    logic [31:0] regs_q [32];
    logic [31:0] ram_q [256];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2;
    logic [31:0] instr;
    logic [31:0] op_a, op_b_reg, op_b, alu_result, ex_target, load_data;
    logic        ex_taken, in_ram, is_led;

    assign rom_address = pc_q;
    assign led         = led_q;
    assign instr       = ifid_instr_q;
    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];

    // Decode; register reads see a same-cycle WB write. A taken branch in EX squashes this slot.
    always_comb begin
        idex_d    = '0;
        idex_d.pc = ifid_pc_q;
        idex_d.rd = instr[11:7];
`ifdef FORWARD_EN
        idex_d.rs1 = rs1;
        idex_d.rs2 = rs2;
`endif
        idex_d.rs1_val = (rs1 == 5'd0) ? '0 :
                         (memwb_q.reg_we && memwb_q.rd == rs1) ? memwb_q.data : regs_q[rs1];
        idex_d.rs2_val = (rs2 == 5'd0) ? '0 :
                         (memwb_q.reg_we && memwb_q.rd == rs2) ? memwb_q.data : regs_q[rs2];
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    idex_d.reg_we = 1'b1;
                    case (funct3)
                        3'b000:  idex_d.alu_op = ALU_ADD;
                        3'b001:  idex_d.alu_op = ALU_SLL;
                        3'b010:  idex_d.alu_op = ALU_SLT;
                        3'b100:  idex_d.alu_op = ALU_XOR;
                        3'b101:  idex_d.alu_op = ALU_SRL;
                        3'b110:  idex_d.alu_op = ALU_OR;
                        3'b111:  idex_d.alu_op = ALU_AND;
                        default: idex_d.reg_we = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    idex_d.reg_we = 1'b1;
                    idex_d.alu_op = ALU_SUB;
                end
            end
            7'b0010011: begin
                idex_d.use_imm = 1'b1;
                idex_d.imm     = {{20{instr[31]}}, instr[31:20]};
                idex_d.reg_we  = 1'b1;
                case (funct3)
                    3'b000:  idex_d.alu_op = ALU_ADD;
                    3'b010:  idex_d.alu_op = ALU_SLT;
                    3'b100:  idex_d.alu_op = ALU_XOR;
                    3'b110:  idex_d.alu_op = ALU_OR;
                    3'b111:  idex_d.alu_op = ALU_AND;
                    3'b001: begin
                        idex_d.alu_op = ALU_SLL;
                        idex_d.reg_we = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        idex_d.alu_op = ALU_SRL;
                        idex_d.reg_we = (funct7 == 7'b0000000);
                    end
                    default: idex_d.reg_we = 1'b0;
                endcase
            end
            7'b0110111: begin
                idex_d.use_imm = 1'b1;
                idex_d.imm     = {instr[31:12], 12'b0};
                idex_d.alu_op  = ALU_PASSB;
                idex_d.reg_we  = 1'b1;
            end
            7'b0000011: if (funct3 == 3'b010) begin
                idex_d.use_imm = 1'b1;
                idex_d.imm     = {{20{instr[31]}}, instr[31:20]};
                idex_d.reg_we  = 1'b1;
                idex_d.mem_re  = 1'b1;
            end
            7'b0100011: if (funct3 == 3'b010) begin
                idex_d.use_imm = 1'b1;
                idex_d.imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                idex_d.mem_we  = 1'b1;
            end
            7'b1100011: begin
                idex_d.imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                idex_d.is_beq = (funct3 == 3'b000);
                idex_d.is_bne = (funct3 == 3'b001);
            end
            7'b1101111: begin
                idex_d.imm    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                idex_d.is_jal = 1'b1;
                idex_d.reg_we = 1'b1;
            end
            default: ;
        endcase
        if (ex_taken) idex_d = '0;
    end

    // Execute: ALU, branch resolution and the JAL link value.
    always_comb begin
        op_a     = idex_q.rs1_val;
        op_b_reg = idex_q.rs2_val;
`ifdef FORWARD_EN
        if (idex_q.rs1 != 5'd0 && exmem_q.reg_we && exmem_q.rd == idex_q.rs1)
            op_a = exmem_q.result;
        else if (idex_q.rs1 != 5'd0 && memwb_q.reg_we && memwb_q.rd == idex_q.rs1)
            op_a = memwb_q.data;
        if (idex_q.rs2 != 5'd0 && exmem_q.reg_we && exmem_q.rd == idex_q.rs2)
            op_b_reg = exmem_q.result;
        else if (idex_q.rs2 != 5'd0 && memwb_q.reg_we && memwb_q.rd == idex_q.rs2)
            op_b_reg = memwb_q.data;
`endif
        op_b = idex_q.use_imm ? idex_q.imm : op_b_reg;
        case (idex_q.alu_op)
            ALU_SUB:   alu_result = op_a - op_b;
            ALU_AND:   alu_result = op_a & op_b;
            ALU_OR:    alu_result = op_a | op_b;
            ALU_XOR:   alu_result = op_a ^ op_b;
            ALU_SLT:   alu_result = {31'b0, ($signed(op_a) < $signed(op_b))};
            ALU_SLL:   alu_result = op_a << op_b[4:0];
            ALU_SRL:   alu_result = op_a >> op_b[4:0];
            ALU_PASSB: alu_result = op_b;
            default:   alu_result = op_a + op_b;
        endcase
        ex_target = idex_q.pc + idex_q.imm;
        ex_taken  = idex_q.is_jal || (idex_q.is_beq && op_a == op_b_reg) ||
                    (idex_q.is_bne && op_a != op_b_reg);
        exmem_d.result     = idex_q.is_jal ? idex_q.pc + 32'd4 : alu_result;
        exmem_d.store_data = op_b_reg;
        exmem_d.rd         = idex_q.rd;
        exmem_d.reg_we     = idex_q.reg_we;
        exmem_d.mem_we     = idex_q.mem_we;
        exmem_d.mem_re     = idex_q.mem_re;
    end

    // Memory: combinational RAM/LED read; anything outside both ranges reads 0.
    always_comb begin
        in_ram    = (exmem_q.result[31:10] == 22'd0);
        is_led    = (exmem_q.result == 32'h0000_1000);
        load_data = in_ram ? ram_q[exmem_q.result[9:2]] : is_led ? {26'b0, led_q} : '0;
        led_d     = (exmem_q.mem_we && is_led) ? exmem_q.store_data[5:0] : led_q;
        memwb_d.data   = exmem_q.mem_re ? load_data : exmem_q.result;
        memwb_d.rd     = exmem_q.rd;
        memwb_d.reg_we = exmem_q.reg_we;
        pc_d           = ex_taken ? ex_target : pc_q + 32'd4;
        ifid_instr_d   = ex_taken ? NOP_INSTR : rom_data;
        ifid_pc_d      = pc_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q         <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
            led_q        <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (enable) begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            idex_q       <= idex_d;
            exmem_q      <= exmem_d;
            memwb_q      <= memwb_d;
            led_q        <= led_d;
            if (memwb_q.reg_we && memwb_q.rd != 5'd0) regs_q[memwb_q.rd] <= memwb_q.data;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (enable && exmem_q.mem_we && in_ram) ram_q[exmem_q.result[9:2]] <= exmem_q.store_data;
    end
endmodule

// File: tb/tb_rv32i_cpu.sv
// tb_rv32i_cpu: directed self-checking bench for rv32i_cpu; ALU vectors from a table, pipeline corner cases as sequences.
// Checks adapt to FORWARD_EN when the macro is defined for the build.
module tb_rv32i_cpu;
    localparam logic [6:0]  OP_R   = 7'b0110011;
    localparam logic [6:0]  OP_I   = 7'b0010011;
    localparam logic [6:0]  OP_LUI = 7'b0110111;
    localparam logic [6:0]  OP_LW  = 7'b0000011;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [31:0] rom_address;
    logic [31:0] rom_data;
    logic [5:0]  led;
    logic [31:0] rom [64];

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic [11:0] a;
        logic [11:0] b;
        logic [31:0] instr;
        logic [31:0] expected;
    } vec_t;
    vec_t vecs[$];

    rv32i_cpu dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .led         (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign rom_data = (rom_address < 32'd256) ? rom[rom_address[7:2]] : NOP;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, OP_I);
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 64; i++) rom[i] = NOP;
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        clearRom();

        vecs.push_back('{"add",      12'd7,   12'd3, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd10});
        vecs.push_back('{"sub",      12'd7,   12'd3, enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 32'd4});
        vecs.push_back('{"sub_wrap", 12'd0,   12'd1, enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 32'hFFFF_FFFF});
        vecs.push_back('{"and",      12'd7,   12'd3, enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 32'd3});
        vecs.push_back('{"or",       12'hFF8, 12'd2, enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3), 32'hFFFF_FFFA});
        vecs.push_back('{"xor",      12'd7,   12'd3, enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd3), 32'd4});
        vecs.push_back('{"slt_neg",  12'hFF8, 12'd2, enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'd1});
        vecs.push_back('{"slt_pos",  12'd7,   12'd3, enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'd0});
        vecs.push_back('{"sll",      12'd7,   12'd3, enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd3), 32'd56});
        vecs.push_back('{"srl",      12'hFF8, 12'd2, enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd3), 32'h3FFF_FFFE});
        vecs.push_back('{"sltu_nop", 12'd1,   12'd2, enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd3), 32'd0});
        vecs.push_back('{"addi_neg", 12'd7,   12'd0, enc_i(12'hFFF, 5'd1, 3'b000, 5'd3, OP_I), 32'd6});
        vecs.push_back('{"slti_0",   12'd7,   12'd0, enc_i(12'hFFF, 5'd1, 3'b010, 5'd3, OP_I), 32'd0});
        vecs.push_back('{"slti_1",   12'hFF8, 12'd0, enc_i(12'h001, 5'd1, 3'b010, 5'd3, OP_I), 32'd1});
        vecs.push_back('{"xori",     12'hFF8, 12'd0, enc_i(12'h7FF, 5'd1, 3'b100, 5'd3, OP_I), 32'hFFFF_F807});
        vecs.push_back('{"andi",     12'hFF8, 12'd0, enc_i(12'h00F, 5'd1, 3'b111, 5'd3, OP_I), 32'd8});
        vecs.push_back('{"ori",      12'd7,   12'd0, enc_i(12'h700, 5'd1, 3'b110, 5'd3, OP_I), 32'h0000_0707});
        vecs.push_back('{"slli",     12'd7,   12'd0, enc_i(12'h004, 5'd1, 3'b001, 5'd3, OP_I), 32'h0000_0070});
        vecs.push_back('{"srli",     12'hFF8, 12'd0, enc_i(12'h01C, 5'd1, 3'b101, 5'd3, OP_I), 32'h0000_000F});
        vecs.push_back('{"srai_nop", 12'hFF8, 12'd0, enc_i(12'h401, 5'd1, 3'b101, 5'd3, OP_I), 32'd0});
        vecs.push_back('{"lui",      12'd0,   12'd0, {20'h80000, 5'd3, OP_LUI},                32'h8000_0000});

        @(negedge clock);
        checkOutput("reset_pc", rom_address, 32'd0);
        checkOutput("reset_led", {26'b0, led}, 32'd0);

        foreach (vecs[i]) begin
            clearRom();
            rom[0] = addi(5'd1, 5'd0, vecs[i].a);
            rom[1] = addi(5'd2, 5'd0, vecs[i].b);
            rom[4] = vecs[i].instr;
            resetDut();
            applyStimulus(12);
            checkOutput(vecs[i].name, dut.regs_q[3], vecs[i].expected);
        end

        // Dependent ADDI pair, x0 write, and a 5-cycle enable pause mid-program
        clearRom();
        rom[0] = addi(5'd5, 5'd0, 12'd7);
        rom[3] = addi(5'd6, 5'd5, 12'hFFD);
        rom[4] = addi(5'd0, 5'd0, 12'd5);
        resetDut();
        applyStimulus(6);
        enable = 1'b0;
        applyStimulus(5);
        checkOutput("pause_pc", rom_address, 32'd24);
        checkOutput("pause_x5", dut.regs_q[5], 32'd7);
        checkOutput("pause_x6", dut.regs_q[6], 32'd0);
        enable = 1'b1;
        applyStimulus(10);
        checkOutput("addi_x5", dut.regs_q[5], 32'd7);
        checkOutput("addi_x6", dut.regs_q[6], 32'd4);
        checkOutput("x0_zero", dut.regs_q[0], 32'd0);

        // LUI/ADDI build a constant, store it, load it back
        clearRom();
        rom[0] = {20'h12345, 5'd7, OP_LUI};
        rom[3] = addi(5'd7, 5'd7, 12'h678);
        rom[6] = enc_s(12'd12, 5'd7, 5'd0);
        rom[9] = enc_i(12'd12, 5'd0, 3'b010, 5'd10, OP_LW);
        resetDut();
        applyStimulus(16);
        checkOutput("lw_x10", dut.regs_q[10], 32'h1234_5678);
        checkOutput("ram_word3", dut.ram_q[3], 32'h1234_5678);

        // BEQ taken skips two ADDIs; BNE not taken falls through
        clearRom();
        rom[0] = enc_b(13'd12, 5'd0, 5'd0, 3'b000);
        rom[1] = addi(5'd11, 5'd11, 12'd1);
        rom[2] = addi(5'd11, 5'd11, 12'd1);
        rom[3] = addi(5'd12, 5'd0, 12'd9);
        rom[4] = enc_b(13'd8, 5'd0, 5'd0, 3'b001);
        rom[5] = addi(5'd13, 5'd0, 12'd1);
        resetDut();
        applyStimulus(3);
        checkOutput("beq_target_pc", rom_address, 32'd12);
        applyStimulus(12);
        checkOutput("beq_x11", dut.regs_q[11], 32'd0);
        checkOutput("beq_x12", dut.regs_q[12], 32'd9);
        checkOutput("bne_x13", dut.regs_q[13], 32'd1);

        // JAL at 0x20 links 0x24, jumps to 0x28, flushes the two younger slots
        clearRom();
        rom[8]  = enc_j(21'd8, 5'd1);
        rom[9]  = addi(5'd14, 5'd0, 12'd1);
        rom[10] = addi(5'd15, 5'd0, 12'd2);
        resetDut();
        applyStimulus(11);
        checkOutput("jal_pc", rom_address, 32'h28);
        applyStimulus(10);
        checkOutput("jal_x1", dut.regs_q[1], 32'h24);
        checkOutput("jal_flush_x14", dut.regs_q[14], 32'd0);
        checkOutput("jal_target_x15", dut.regs_q[15], 32'd2);

        // LED store/load, out-of-range access at 0x200C, then reset
        clearRom();
        rom[0] = addi(5'd5, 5'd0, 12'h02A);
        rom[1] = {20'h00001, 5'd6, OP_LUI};
        rom[2] = {20'h00002, 5'd9, OP_LUI};
        rom[4] = enc_s(12'd0, 5'd5, 5'd6);
        rom[5] = enc_s(12'd12, 5'd5, 5'd9);
        rom[7] = enc_i(12'd0, 5'd6, 3'b010, 5'd8, OP_LW);
        rom[8] = enc_i(12'd12, 5'd9, 3'b010, 5'd16, OP_LW);
        resetDut();
        applyStimulus(16);
        checkOutput("led_value", {26'b0, led}, 32'h2A);
        checkOutput("led_readback", dut.regs_q[8], 32'h2A);
        checkOutput("oob_read", dut.regs_q[16], 32'd0);
        checkOutput("oob_no_write", dut.ram_q[3], 32'h1234_5678);
        resetDut();
        checkOutput("rst_led", {26'b0, led}, 32'd0);
        checkOutput("rst_pc", rom_address, 32'd0);
        checkOutput("rst_x5", dut.regs_q[5], 32'd0);

        // Back-to-back dependents: forwarded values, or stale zeros without forwarding
        clearRom();
        rom[0] = addi(5'd5, 5'd0, 12'd1);
        rom[1] = enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd6);
        rom[2] = enc_r(7'h00, 5'd5, 5'd6, 3'b000, 5'd7);
        resetDut();
        applyStimulus(12);
`ifdef FORWARD_EN
        checkOutput("fwd_x6", dut.regs_q[6], 32'd2);
        checkOutput("fwd_x7", dut.regs_q[7], 32'd3);
`else
        checkOutput("nofwd_x6", dut.regs_q[6], 32'd0);
        checkOutput("nofwd_x7", dut.regs_q[7], 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
